// File: rtl/twiddle_seq_par.sv
// Multi-lane twiddle sequencer for a parallel radix-2 DIF FFT: streams LANES coefficients per
// beat for every stage of one frame under valid/ready, with optional IFFT conjugation.
module twiddle_seq_par #(
  parameter int NBITS = 8,
  parameter int N     = 16,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*NBITS-1:0]       coeff_rom,
  input  logic                     start,
  input  logic                     inverse,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*2*NBITS-1:0] twiddle,
  output logic [$clog2(N)-1:0]     stage,
  output logic                     stage_last,
  output logic                     frame_done,
  output logic [1:0]               dbg_state
);
  localparam int SW  = $clog2(N);
  localparam int BPS = N / (2 * LANES);
  localparam int BW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [NBITS-1:0] IM_MIN     = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] IM_MAX     = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [BW-1:0]    BEAT_LAST  = BW'(BPS - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(SW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                   state, state_next;
  logic [BW-1:0]            beat, nxt_beat;
  logic [SW-1:0]            nxt_stage;
  logic                     inv, nxt_inv;
  logic                     load, clear, xfer;
  logic [LANES*2*NBITS-1:0] tw_next;
  int                       j, s, k;
  logic [2*NBITS-1:0]       entry;
  logic [NBITS-1:0]         im;

  // Handshake: a beat moves on any cycle with out_valid && out_ready; while out_valid is high
  // and out_ready is low, twiddle/stage/stage_last hold, and out_valid never drops mid-beat.
  assign out_valid  = (state == RUN);
  assign busy       = (state == RUN);
  assign frame_done = (state == DONE);
  assign dbg_state  = state;
  assign xfer       = out_valid && out_ready;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    nxt_stage  = stage;
    nxt_beat   = beat;
    nxt_inv    = inv;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
          nxt_stage  = '0;
          nxt_beat   = '0;
          nxt_inv    = inverse;
        end
      end
      RUN: begin
        if (xfer) begin
          if (beat == BEAT_LAST && stage == STAGE_LAST) begin
            state_next = DONE;
            clear      = 1'b1;
          end else begin
            load = 1'b1;
            if (beat == BEAT_LAST) begin
              nxt_stage = stage + 1'b1;
              nxt_beat  = '0;
            end else begin
              nxt_beat = beat + 1'b1;
            end
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Twiddles for the beat about to be loaded; the stride doubles with each stage.
  always_comb begin
    tw_next = '0;
    j       = 0;
    s       = 0;
    k       = 0;
    entry   = '0;
    im      = '0;
    for (int l = 0; l < LANES; l++) begin
      j     = int'(nxt_beat) * LANES + l;
      s     = int'(nxt_stage);
      k     = (j & ((N >> (s + 1)) - 1)) << s;
      entry = coeff_rom[(N/2 - 1 - k) * 2 * NBITS +: 2 * NBITS];
      im    = entry[NBITS-1:0];
      if (nxt_inv) im = (im == IM_MIN) ? IM_MAX : -im;
      tw_next[(LANES - 1 - l) * 2 * NBITS +: 2 * NBITS] = {entry[2*NBITS-1:NBITS], im};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      stage      <= '0;
      beat       <= '0;
      inv        <= 1'b0;
      twiddle    <= '0;
      stage_last <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        stage      <= nxt_stage;
        beat       <= nxt_beat;
        inv        <= nxt_inv;
        twiddle    <= tw_next;
        stage_last <= (nxt_beat == BEAT_LAST);
      end else if (clear) begin
        stage      <= '0;
        beat       <= '0;
        inv        <= 1'b0;
        twiddle    <= '0;
        stage_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_seq_par.sv
// Bench for twiddle_seq_par: spec-table frames, stalls, IFFT saturation, ignored starts,
// mid-frame reset, random frames against a queue model, and an N=8/LANES=1 instance.
module tb_twiddle_seq_par;
  logic         clk = 1'b0;
  logic         rst = 1'b0;

  logic [127:0] rom0;
  logic         start0, inv0, ready0, busy0, valid0, last0, done0;
  logic [63:0]  tw0;
  logic [3:0]   stg0;
  logic [1:0]   dbg0;

  logic [63:0]  rom1;
  logic         start1, inv1, ready1, busy1, valid1, last1, done1;
  logic [15:0]  tw1;
  logic [2:0]   stg1;
  logic [1:0]   dbg1;

  int           n_vec = 0;
  int           n_err = 0;
  int           rom_re[8], rom_im[8];
  int           r1_re[4], r1_im[4];
  logic [63:0]  exp_q[$];
  int           exp_stage_q[$];
  bit           exp_last_q[$];
  logic [63:0]  first_tw;

  typedef struct {
    int k0, k1, k2, k3;
    int stg;
    bit last;
  } vec_t;
  vec_t tbl[8];

  twiddle_seq_par #(.NBITS(8), .N(16), .LANES(4)) u0 (
    .clk(clk), .rst(rst), .coeff_rom(rom0), .start(start0), .inverse(inv0),
    .busy(busy0), .out_valid(valid0), .out_ready(ready0), .twiddle(tw0),
    .stage(stg0), .stage_last(last0), .frame_done(done0), .dbg_state(dbg0)
  );

  twiddle_seq_par #(.NBITS(8), .N(8), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .coeff_rom(rom1), .start(start1), .inverse(inv1),
    .busy(busy1), .out_valid(valid1), .out_ready(ready1), .twiddle(tw1),
    .stage(stg1), .stage_last(last1), .frame_done(done1), .dbg_state(dbg1)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [15:0] lane_word(int k, bit inv);
    int im;
    im = rom_im[k];
    if (inv) im = (-im > 127) ? 127 : -im;
    return {8'(rom_re[k]), 8'(im)};
  endfunction

  task automatic pack_rom;
    for (int k = 0; k < 8; k++) rom0[(7 - k) * 16 +: 16] = {8'(rom_re[k]), 8'(rom_im[k])};
  endtask

  task automatic random_rom;
    for (int k = 0; k < 8; k++) begin
      rom_re[k] = int'($urandom_range(0, 255)) - 128;
      rom_im[k] = int'($urandom_range(0, 255)) - 128;
    end
    pack_rom();
  endtask

  task automatic clear_exp;
    exp_q.delete();
    exp_stage_q.delete();
    exp_last_q.delete();
  endtask

  // Every butterfly of every stage in order, then grouped four per beat.
  task automatic model_frame(input bit inv);
    int ks[$];
    logic [63:0] w;
    clear_exp();
    for (int st = 0; st < 4; st++)
      for (int bf = 0; bf < 8; bf++) ks.push_back((bf % (16 >> (st + 1))) * (1 << st));
    for (int b = 0; b < 8; b++) begin
      w = '0;
      for (int l = 0; l < 4; l++) w = {w[47:0], lane_word(ks[b * 4 + l], inv)};
      exp_q.push_back(w);
      exp_stage_q.push_back(b / 2);
      exp_last_q.push_back(b % 2 == 1);
    end
  endtask

  task automatic load_table;
    clear_exp();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({lane_word(tbl[i].k0, 0), lane_word(tbl[i].k1, 0),
                       lane_word(tbl[i].k2, 0), lane_word(tbl[i].k3, 0)});
      exp_stage_q.push_back(tbl[i].stg);
      exp_last_q.push_back(tbl[i].last);
    end
  endtask

  // driver: mode 0 = ready always, 1 = stall stall_len cycles on stall_beat, 2 = random ready
  task automatic run_frame(input bit inv, input int mode, input int stall_beat,
                           input int stall_len, input bit spam);
    int beats, cyc, stalls, stalled;
    bit rdy;
    beats = 0; cyc = 1; stalls = 0; stalled = 0;
    inv0 = inv; ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    first_tw = tw0;
    while (beats < 8 && cyc < 100) begin
      check("out_valid", valid0, 1);
      check("busy", busy0, 1);
      check("frame_done_early", done0, 0);
      if (exp_q.size() > 0) begin
        check("twiddle", tw0, exp_q[0]);
        check("stage", stg0, exp_stage_q[0]);
        check("stage_last", last0, exp_last_q[0]);
      end
      case (mode)
        1:       rdy = !(beats == stall_beat && stalled < stall_len);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      if (!rdy) begin
        stalls++;
        if (beats == stall_beat) stalled++;
      end
      ready0 = rdy;
      if (spam) begin
        start0 = ($urandom_range(0, 1) != 0);
        inv0   = ($urandom_range(0, 1) != 0);
      end
      if (rdy && valid0) begin
        beats++;
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(exp_stage_q.pop_front());
          void'(exp_last_q.pop_front());
        end
      end
      tick();
      cyc++;
    end
    check("beat_count", beats, 8);
    ready0 = 1'b1;
    if (spam) start0 = 1'b1;
    check("done_pulse", done0, 1);
    check("done_cycle", cyc, 9 + stalls);
    check("valid_after_last", valid0, 0);
    check("busy_after_last", busy0, 0);
    tick();
    start0 = 1'b0;
    check("done_one_cycle", done0, 0);
    check("idle_after_done", valid0, 0);
  endtask

  initial begin
    int kseq[12];
    int beats, cyc;
    bit rdy;
    kseq = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};
    tbl[0] = '{0, 1, 2, 3, 0, 1'b0};
    tbl[1] = '{4, 5, 6, 7, 0, 1'b1};
    tbl[2] = '{0, 2, 4, 6, 1, 1'b0};
    tbl[3] = '{0, 2, 4, 6, 1, 1'b1};
    tbl[4] = '{0, 4, 0, 4, 2, 1'b0};
    tbl[5] = '{0, 4, 0, 4, 2, 1'b1};
    tbl[6] = '{0, 0, 0, 0, 3, 1'b0};
    tbl[7] = '{0, 0, 0, 0, 3, 1'b1};
    start0 = 0; inv0 = 0; ready0 = 0; start1 = 0; inv1 = 0; ready1 = 0;
    rom0 = '0; rom1 = '0;

    // reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_valid", valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_twiddle", tw0, 0);
    check("rst_stage", stg0, 0);
    check("rst_last", last0, 0);
    check("rst_done", done0, 0);
    check("rst_valid1", valid1, 0);
    rst = 1'b1;
    tick();

    // spec table frame, continuous ready
    for (int k = 0; k < 8; k++) begin
      rom_re[k] = 16 * k + 1;
      rom_im[k] = -(9 * k + 3);
    end
    pack_rom();
    load_table();
    run_frame(0, 0, 0, 0, 0);

    // same table with a 3-cycle stall on beat 2
    load_table();
    run_frame(0, 1, 2, 3, 0);

    // IFFT with the most negative im at k=2
    random_rom();
    rom_im[2] = -128;
    pack_rom();
    model_frame(1);
    run_frame(1, 0, 0, 0, 0);
    check("sat_im_k2", first_tw[23:16], 8'h7f);
    check("re_k2_unchanged", first_tw[31:24], 8'(rom_re[2]));

    // starts during RUN and DONE ignored; next IDLE start accepted
    model_frame(0);
    run_frame(0, 0, 0, 0, 1);
    model_frame(0);
    run_frame(0, 0, 0, 0, 0);

    // reset while beat 3 is presented
    inv0 = 1'b0; ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    check("pre_rst_stage", stg0, 1);
    check("pre_rst_last", last0, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_valid", valid0, 0);
    check("abort_busy", busy0, 0);
    check("abort_twiddle", tw0, 0);
    check("abort_stage", stg0, 0);
    check("abort_last", last0, 0);
    check("abort_done", done0, 0);
    repeat (4) begin
      tick();
      check("abort_no_done", done0, 0);
      check("abort_idle", valid0, 0);
    end
    model_frame(0);
    run_frame(0, 0, 0, 0, 0);

    // random frames
    repeat (20) begin
      bit inv;
      random_rom();
      inv = ($urandom_range(0, 1) != 0);
      model_frame(inv);
      run_frame(inv, 2, 0, 0, ($urandom_range(0, 1) != 0));
    end

    // N=8, LANES=1 instance
    for (int k = 0; k < 4; k++) begin
      r1_re[k] = 10 * k + 5;
      r1_im[k] = 100 - 7 * k;
      rom1[(3 - k) * 16 +: 16] = {8'(r1_re[k]), 8'(r1_im[k])};
    end
    inv1 = 1'b0; ready1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    beats = 0; cyc = 1;
    while (beats < 12 && cyc < 100) begin
      check("l1_valid", valid1, 1);
      check("l1_twiddle", tw1, {8'(r1_re[kseq[beats]]), 8'(r1_im[kseq[beats]])});
      check("l1_stage", stg1, beats / 4);
      check("l1_last", last1, beats % 4 == 3);
      rdy = ($urandom_range(0, 2) != 0);
      ready1 = rdy;
      if (rdy && valid1) beats++;
      tick();
      cyc++;
    end
    check("l1_beat_count", beats, 12);
    check("l1_done", done1, 1);
    check("l1_valid_end", valid1, 0);
    ready1 = 1'b0;
    tick();
    check("l1_done_one_cycle", done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
